// File: rtl/s_box.sv
`default_nettype none
// ============================================================================
// Module      : s_box
// Description : AES forward S-box with a zero-latency combinational output and
//               a registered copy (asynchronous active-low reset).
// Revision    : 1.0 - initial release
// ============================================================================
module s_box (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:7] in,
    output logic [0:7] out,
    output logic [0:7] out_q
);

    localparam logic [7:0] c_AFFINE = 8'h63;

    // Carry-less multiply reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 equals a^-1 for a != 0 and yields 0 for a == 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // LSB-first views: an ascending-range port copies across by numeric value.
    logic [7:0] w_in;
    logic [7:0] w_inv;
    logic [7:0] w_sub;
    logic [7:0] r_out_q;

    assign w_in  = in;
    assign w_inv = gf_inv(w_in);

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_affine
            assign w_sub[i] = w_inv[i]
                            ^ w_inv[(i + 4) % 8]
                            ^ w_inv[(i + 5) % 8]
                            ^ w_inv[(i + 6) % 8]
                            ^ w_inv[(i + 7) % 8]
                            ^ c_AFFINE[i];
        end
    endgenerate

    assign out = w_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q <= 8'h00;
        end else begin
            r_out_q <= w_sub;
        end
    end

    assign out_q = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_s_box.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_box
// Description : Self-checking bench for s_box against a brute-force GF model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_box;

    logic       clk;
    logic       rst_n;
    logic       clk_en;
    logic       cmp_en;
    logic [0:7] din;
    logic [0:7] dout;
    logic [0:7] doutq;
    logic [7:0] exp_q;
    int         errors;
    int         checks;

    s_box dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (din),
        .out   (dout),
        .out_q (doutq)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    function automatic int gmul(int a, int b);
        int p;
        p = 0;
        for (int k = 0; k < 8; k++) begin
            if ((b & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ 'h11B;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic int rotl8(int v, int n);
        return ((v << n) | (v >> (8 - n))) & 'hFF;
    endfunction

    // Inverse by exhaustive search, then the affine map as rotations.
    function automatic logic [7:0] sbox_ref(int x);
        int b;
        b = 0;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, y) == 1) b = y;
        end
        return 8'(b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 'h63);
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if ($isunknown(act) || act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
        end
    endtask

    // Expected registered output: loads S(in) on each edge out of reset.
    always @(posedge clk) begin
        if (rst_n === 1'b1) exp_q = sbox_ref(din);
    end
    always @(negedge rst_n) exp_q = 8'h00;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_track", dout, sbox_ref(din));
            check("out_q_track", doutq, exp_q);
        end
    end

    logic [7:0] lit_in  [8] = '{8'h09, 8'h98, 8'hAF, 8'h00, 8'h01, 8'h53, 8'hFF, 8'h10};
    logic [7:0] lit_out [8] = '{8'h01, 8'h46, 8'h79, 8'h63, 8'h7C, 8'hED, 8'h16, 8'hCA};
    bit         seen    [256];

    initial begin
        int distinct;
        logic [7:0] v;
        errors = 0;
        checks = 0;
        clk_en = 1'b0;
        cmp_en = 1'b0;
        exp_q  = 8'h00;
        din    = 8'h00;
        rst_n  = 1'b0;
        #1;
        check("reset_out_q", doutq, 8'h00);
        rst_n = 1'b1;

        // Combinational lookups with no clock running.
        for (int k = 0; k < 8; k++) begin
            din = lit_in[k];
            #5;
            check("literal_out", dout, lit_out[k]);
            check("model_pin", sbox_ref(int'(lit_in[k])), lit_out[k]);
        end
        check("no_clock_out_q", doutq, 8'h00);

        distinct = 0;
        for (int k = 0; k < 256; k++) begin
            din = 8'(k);
            #1;
            check("sweep_out", dout, sbox_ref(k));
            if (!$isunknown(dout) && !seen[int'(dout)]) begin
                seen[int'(dout)] = 1'b1;
                distinct++;
            end
        end
        check("bijection_count", 8'(distinct - 1), 8'hFF);

        // Clocked random traffic.
        clk_en = 1'b1;
        cmp_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            din = 8'($urandom_range(0, 255));
        end

        // Reset held with clock toggling, then release.
        @(posedge clk);
        #2;
        din   = 8'h10;
        rst_n = 1'b0;
        #1;
        check("rst_async_q", doutq, 8'h00);
        check("rst_out_live", dout, 8'hCA);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_q", doutq, 8'h00);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_q", doutq, 8'hCA);

        // Mid-stream asynchronous reset between edges.
        for (int r = 0; r < 5; r++) begin
            repeat (4) begin
                @(posedge clk);
                #2;
                din = 8'($urandom_range(0, 255));
            end
            #1;
            rst_n = 1'b0;
            #1;
            check("mid_rst_q", doutq, 8'h00);
            @(posedge clk);
            #2;
            v     = 8'($urandom_range(0, 255));
            din   = v;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check("mid_release_q", doutq, sbox_ref(int'(v)));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
